dc_delay_sum: RTL
=================

Name: dc_delay_sum

Overview:
- Parametrised delay line with a moving-window sum for delay-correlation (DC) metric computation in the OFDM receiver synchroniser.
- Accepts an AXI-stream sample stream and outputs two values per sample:
  - the sample delayed by DEPTH accepted samples;
  - the signed sum of the last DEPTH samples.
- Replaces fixed 32-bit single-stage registers in the metric path with one configurable block that supports backpressure.

Parameters:
- DATA_W, 32: sample width, signed two's complement.
- DEPTH, 16: window length and delay in accepted samples. Must be at least 2; any integer is allowed.
- SUM_W, DATA_W+clog2(DEPTH): sum width. It never overflows for DEPTH samples.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- clr  in  1  synchronous flush. Same effect as reset; rst_n has priority.
- s_tdata  in  DATA_W  input sample.
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_tdly  out  DATA_W  delayed sample x[n-DEPTH].
- m_tsum  out  SUM_W  window sum.
- m_tfull  out  1  window full: DEPTH samples have been accepted since the last reset/clr.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.

Behaviour:
- Reset (rst_n=0 at a clk edge) and clr=1: next state is m_tvalid=0, m_tdly=0, m_tsum=0, m_tfull=0, count=0, wptr=0, internal sum=0. Buffer RAM contents are not cleared.
- s_tready = m_tready | ~m_tvalid. This is combinational, from a single output register stage.
- Accept occurs when s_tvalid & s_tready.
  - old = buf[wptr] if count==DEPTH, else 0. Stale RAM contents are therefore never visible.
  - buf[wptr] <= s_tdata.
  - wptr wraps from DEPTH-1 to 0.
  - count saturates at DEPTH.
  - sum_next = sum + sext(s_tdata) - sext(old), computed at SUM_W.
  - The output register loads m_tdly=old, m_tsum=sum_next, and m_tfull=(count_next==DEPTH).
  - m_tvalid <= 1.
- Latency: 1 cycle from accept to m_tvalid.
- Throughput: 1 sample per clock while m_tready=1.
- No accept and m_tready=1: m_tvalid <= 0. Data outputs hold their last values.
- No accept and m_tready=0: all outputs hold, and AXI stability is preserved.
- Simultaneous accept and output handshake: the new sample replaces the old one with no bubble.
- s_tvalid low (gaps): no state change apart from m_tvalid clearing once consumed.
- Reset or clr mid-burst: an in-flight output is dropped. The first sample after the flush sees old=0.

Optional Feature:
- Macro: DC_MEAN_EN.
- Defined:
  - DEPTH must be a power of two; elaboration fails otherwise.
  - m_tsum carries the window mean, sign-extended to SUM_W.
  - Mean = (sum + DEPTH/2) >>> log2(DEPTH), i.e. round-half-up with an arithmetic shift.
  - The shift is applied to sum_next before the output register, so latency is unchanged.
- Undefined: m_tsum is the raw SUM_W sum, and any DEPTH is allowed.

Decomposition:
- Package dc_sync_pkg:
  - clog2 function;
  - default DATA_W and DEPTH constants;
  - SUM_W derivation helper.
- Sub-module dc_circ_buf: DEPTH x DATA_W circular buffer.
  - Combinational read at wptr.
  - Write on enable.
  - Wrap pointer with non-power-of-two wrap and synchronous reset of the pointer only.
- The top level holds count, sum, output register and handshake.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles -> m_tvalid=0, m_tsum=0, m_tdly=0, m_tfull=0, s_tready=1.
- Fill and slide: DEPTH=4, DATA_W=8, feed 1,2,3,4,5,6 back-to-back with m_tready=1 -> m_tsum=1,3,6,10,14,18; m_tdly=0,0,0,0,1,2; m_tfull rises with the 4th output.
- Signed extreme: DEPTH=4, feed -128 x4 -> m_tsum=-512 (SUM_W=10). Then feed 127 x4 -> final m_tsum=508, with no wrap.
- Backpressure: hold m_tready=0 for 3 cycles mid-stream while s_tvalid=1 -> s_tready=0, outputs stable, no sample lost or duplicated; the sum sequence matches the reference model.
- clr mid-stream: after 6 samples assert clr for 1 cycle, then feed 7 -> m_tsum=7, m_tdly=0, m_tfull=0. The next 3 outputs show m_tdly=0.
- DC_MEAN_EN: DEPTH=4, feed 1,2,3,4 -> 4th m_tsum=3, since (10+2)>>>2. Feed -128 x4 -> m_tsum=-128.

Source files
------------

// File: rtl/dc_sync_pkg.sv
// Shared sizing helpers and defaults for the DC synchroniser metric path.
package dc_sync_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 16;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  // Width that holds the signed sum of depth samples of data_w bits.
  function automatic int unsigned sum_width(input int unsigned data_w,
                                            input int unsigned depth);
    return data_w + clog2(depth);
  endfunction

endpackage

// File: rtl/dc_circ_buf.sv
// DEPTH x DATA_W circular buffer: combinational read at the write pointer,
// pointer wraps at DEPTH-1 (any DEPTH); only the pointer is reset.
module dc_circ_buf
  import dc_sync_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned PTR_W = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;

  assign rdata = mem[wptr];

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wptr <= '0;
    end else if (we) begin
      wptr <= (wptr == PTR_W'(DEPTH - 1)) ? '0 : wptr + PTR_W'(1);
    end
  end

endmodule

// File: rtl/dc_delay_sum.sv
// Delay line plus moving-window sum with a single AXI-stream output stage.
// Optional macro DC_MEAN_EN: m_tsum carries the rounded window mean.
module dc_delay_sum
  import dc_sync_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned SUM_W  = sum_width(DATA_W, DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  output logic [DATA_W-1:0] m_tdly,
  output logic [SUM_W-1:0]  m_tsum,
  output logic              m_tfull,
  output logic              m_tvalid,
  input  logic              m_tready
);

  localparam int unsigned CNT_W = clog2(DEPTH + 1);
  localparam int unsigned EXT_W = SUM_W - DATA_W;

  if (DEPTH < 2) begin : g_depth_min
    $error("dc_delay_sum: DEPTH must be at least 2");
  end

  logic              flush;
  logic              accept;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_next;
  logic [SUM_W-1:0]  out_sum;
  logic [SUM_W-1:0]  data_ext;
  logic [SUM_W-1:0]  old_ext;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] old;

  assign flush    = ~rst_n | clr;
  assign s_tready = m_tready | ~m_tvalid;
  assign accept   = s_tvalid & s_tready;

  dc_circ_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .we    (accept),
    .wdata (s_tdata),
    .rdata (rd_data)
  );

  // Until the window is full the evicted sample is zero, hiding stale RAM.
  assign full       = (count == CNT_W'(DEPTH));
  assign old        = full ? rd_data : '0;
  assign count_next = full ? count : count + CNT_W'(1);
  assign data_ext   = {{EXT_W{s_tdata[DATA_W-1]}}, s_tdata};
  assign old_ext    = {{EXT_W{old[DATA_W-1]}}, old};
  assign sum_next   = sum + data_ext - old_ext;

`ifdef DC_MEAN_EN
  localparam int unsigned LOG2_DEPTH = clog2(DEPTH);

  if ((32'd1 << LOG2_DEPTH) != DEPTH) begin : g_depth_pow2
    $error("dc_delay_sum: DC_MEAN_EN requires a power-of-two DEPTH");
  end

  // Round half up, then arithmetic shift; cannot overflow SUM_W.
  logic signed [SUM_W-1:0] rounded;
  assign rounded = $signed(sum_next + SUM_W'(DEPTH / 2));
  assign out_sum = SUM_W'(rounded >>> LOG2_DEPTH);
`else
  assign out_sum = sum_next;
`endif

  always_ff @(posedge clk) begin
    if (flush) begin
      count <= '0;
      sum   <= '0;
    end else if (accept) begin
      count <= count_next;
      sum   <= sum_next;
    end
  end

  // Single output stage; data holds when nothing new is accepted.
  always_ff @(posedge clk) begin
    if (flush) begin
      m_tvalid <= 1'b0;
      m_tdly   <= '0;
      m_tsum   <= '0;
      m_tfull  <= 1'b0;
    end else if (accept) begin
      m_tvalid <= 1'b1;
      m_tdly   <= old;
      m_tsum   <= out_sum;
      m_tfull  <= (count_next == CNT_W'(DEPTH));
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule
